uart_axi_arbiter: RTL

- Shares the single AXI4-Lite master port of the AXI UART Lite core between two requesters: a TX byte sender and an RX byte receiver.
- For each granted request it runs the full register sequence:
  - reads the status register (STAT);
  - writes the TX FIFO or reads the RX FIFO;
  - completes the AXI response phase;
  - returns a one-cycle acknowledge to the requester.
- Sits between the core's I/O logic and the uartlite IP.

---
 rtl/uart_axi_pkg.sv | 24 ++
 rtl/uart_rr_arb.sv | 31 +++
 rtl/uart_axi_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_axi_pkg.sv
// Shared constants and state type for the UART Lite AXI4-Lite arbiter.
// Register offsets and status bits follow the AXI UART Lite register map.
package uart_axi_pkg;

  localparam logic [3:0] RX_FIFO = 4'h0;
  localparam logic [3:0] TX_FIFO = 4'h4;
  localparam logic [3:0] STAT    = 4'h8;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  localparam logic [1:0] OKAY = 2'b00;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AR_STAT = 3'd1,
    R_STAT  = 3'd2,
    W_TX    = 3'd3,
    B_TX    = 3'd4,
    AR_RX   = 3'd5,
    R_RX    = 3'd6
  } arb_state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-requester round-robin grant. Grants are combinational; the priority
// flop points at the requester that did not win the most recent grant.
module uart_rr_arb #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_tx,
  input  logic req_rx,
  output logic gnt_tx,
  output logic gnt_rx
);

  // prio = 0: TX wins a tie, prio = 1: RX wins a tie
  logic prio;

  assign gnt_tx = en && req_tx && (!req_rx || !prio);
  assign gnt_rx = en && req_rx && (!req_tx ||  prio);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= RR_INIT;
    end else if (gnt_tx) begin
      prio <= 1'b1;
    end else if (gnt_rx) begin
      prio <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_axi_arbiter.sv
// Shares the AXI UART Lite AXI4-Lite master between a TX byte sender and an
// RX byte receiver. Optional response-error capture: UART_ARB_ERR_CAPTURE_EN.
module uart_axi_arbiter
  import uart_axi_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int RR_INIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_ack,
  input  logic        rx_req,
  output logic [7:0]  rx_data,
  output logic        rx_ack,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [3:0]  axi_awaddr,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  input  logic [1:0]  axi_bresp,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  output logic [3:0]  axi_araddr,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
`ifdef UART_ARB_ERR_CAPTURE_EN
  output logic        err_sticky,
  output logic [1:0]  err_resp,
`endif
  output logic [2:0]  dbg_state
);

  localparam int GAP_W = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);

  arb_state_e       state, state_n;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_rx;
  logic             aw_done, w_done;
  logic [7:0]       wbyte;
  logic             grant_en, gnt_tx, gnt_rx;
  logic             aw_fin, w_fin;
  logic             unused_bits;

  assign grant_en = (state == IDLE) && (gap_cnt == '0);

  uart_rr_arb #(
    .RR_INIT (RR_INIT != 0)
  ) u_rr_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (grant_en),
    .req_tx (tx_req),
    .req_rx (rx_req),
    .gnt_tx (gnt_tx),
    .gnt_rx (gnt_rx)
  );

  // Handshake rule on every channel: a transfer happens in a cycle where
  // valid and ready are both high; a valid, once raised, stays high with
  // stable address/data until that cycle, and drops in the following cycle.
  assign axi_arvalid = (state == AR_STAT) || (state == AR_RX);
  assign axi_araddr  = (state == AR_STAT) ? STAT : RX_FIFO;
  assign axi_rready  = (state == R_STAT) || (state == R_RX);
  assign axi_awvalid = (state == W_TX) && !aw_done;
  assign axi_wvalid  = (state == W_TX) && !w_done;
  assign axi_awaddr  = (state == W_TX) ? TX_FIFO : 4'h0;
  assign axi_wdata   = {24'd0, wbyte};
  assign axi_wstrb   = 4'b0001;
  assign axi_bready  = (state == B_TX);
  assign dbg_state   = state;

  // AW and W complete independently; each may finish before the other
  assign aw_fin = aw_done || (axi_awvalid && axi_awready);
  assign w_fin  = w_done  || (axi_wvalid  && axi_wready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (gnt_tx || gnt_rx) state_n = AR_STAT;
      end
      AR_STAT: begin
        if (axi_arready) state_n = R_STAT;
      end
      R_STAT: begin
        if (axi_rvalid) begin
          if (!grant_rx) begin
            state_n = axi_rdata[STAT_TX_FULL] ? IDLE : W_TX;
          end else begin
            state_n = axi_rdata[STAT_RX_VALID] ? AR_RX : IDLE;
          end
        end
      end
      W_TX: begin
        if (aw_fin && w_fin) state_n = B_TX;
      end
      B_TX: begin
        if (axi_bvalid) state_n = IDLE;
      end
      AR_RX: begin
        if (axi_arready) state_n = R_RX;
      end
      R_RX: begin
        if (axi_rvalid) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt  <= '0;
      grant_rx <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      wbyte    <= 8'd0;
      rx_data  <= 8'd0;
      tx_ack   <= 1'b0;
      rx_ack   <= 1'b0;
    end else begin
      tx_ack <= 1'b0;
      rx_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
          if (gnt_rx) begin
            grant_rx <= 1'b1;
          end else if (gnt_tx) begin
            grant_rx <= 1'b0;
          end
        end
        R_STAT: begin
          // A poll that found no room / no data backs off before re-polling
          if (axi_rvalid && (state_n == IDLE)) gap_cnt <= GAP_LOAD;
          if (state_n == W_TX) begin
            wbyte   <= tx_data;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        W_TX: begin
          aw_done <= aw_fin;
          w_done  <= w_fin;
        end
        B_TX: begin
          if (axi_bvalid) tx_ack <= 1'b1;
        end
        R_RX: begin
          if (axi_rvalid) begin
            rx_data <= axi_rdata[7:0];
            rx_ack  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_ARB_ERR_CAPTURE_EN
  logic r_bad, b_bad;

  assign r_bad = axi_rvalid && axi_rready && (axi_rresp != OKAY);
  assign b_bad = axi_bvalid && axi_bready && (axi_bresp != OKAY);

  // Only the first non-OKAY response is remembered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_resp   <= OKAY;
    end else if (!err_sticky && (r_bad || b_bad)) begin
      err_sticky <= 1'b1;
      err_resp   <= r_bad ? axi_rresp : axi_bresp;
    end
  end

  assign unused_bits = ^axi_rdata[31:8];
`else
  assign unused_bits = ^{axi_rdata[31:8], axi_rresp, axi_bresp};
`endif

endmodule
